uart_servo_multi: RTL and testbench
===================================

UART_SERVO_MULTI -- requirements
Module: uart_servo_multi

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate.
REQ-003 SHALL have parameter N_CH, default 4, number of servo channels (1..16).
REQ-004 SHALL have parameter RESET_POS, default 125, position code loaded at reset (1500 us).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx_pin  input  1  UART RX line, 8N1, idle high, asynchronous to clk.
REQ-008 SHALL have port servo_pwm  output  N_CH  one PWM output per channel.
REQ-009 SHALL have port frame_ok  output  1  one-cycle pulse when a command is committed.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-011 SHALL pass rx_pin through a 2-FF synchronizer before any use.
REQ-012 SHALL use bit period BIT = CLK_HZ/BAUD clocks (integer truncation); a start bit SHALL be detected on a high-to-low edge and re-checked low at BIT/2, else ignored.
REQ-013 SHALL sample 8 data bits LSB first at bit centres, then the stop bit; stop bit low = framing error: byte discarded, frame_err pulsed, parser to IDLE.
REQ-014 Command frame SHALL be: header 0xA5, channel byte, position byte (plus checksum byte when CKSUM enabled).
REQ-015 Parser FSM states SHALL be IDLE, GET_CH, GET_POS, GET_SUM (CKSUM only), COMMIT; each received byte advances one state; COMMIT lasts one cycle, then IDLE.
REQ-016 In IDLE, bytes other than 0xA5 SHALL be silently dropped, with no frame_err.
REQ-017 In GET_CH and GET_POS, 0xA5 SHALL be treated as data, not as a resync.
REQ-018 Channel byte >= N_CH SHALL cause frame_err and no register update, evaluated at COMMIT.
REQ-019 Position codes > 250 SHALL be clamped to 250 before storage.
REQ-020 Pulse width SHALL be 1000 + 4*pos microseconds (1000..2000 us); PWM period SHALL be 20000 us; timing SHALL come from a 1 us tick of CLK_HZ/1_000_000 clocks.
REQ-021 All channels SHALL share one period counter; each output SHALL be high from count 0 until count = its pulse width.
REQ-022 A committed position SHALL be staged and take effect only at the next period start (count 0), so no pulse is truncated or extended.
REQ-023 Two commits to one channel within a period SHALL result in the later value being used.
REQ-024 frame_ok SHALL pulse in the COMMIT cycle of a valid frame; frame_ok and frame_err SHALL never be high together.

Reset
REQ-025 With rst low, servo_pwm, frame_ok and frame_err SHALL be 0, the FSM SHALL be in IDLE, the UART SHALL be idle, and the counters SHALL be 0.
REQ-026 With rst low, active and staged positions SHALL equal RESET_POS.
REQ-027 A reset mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh start bit.

Configuration
REQ-028 Macro UART_SERVO_CKSUM_EN defined: a fourth byte SHALL be required equal to channel XOR position (before clamp); on mismatch, frame_err and no update.
REQ-029 Macro UART_SERVO_CKSUM_EN undefined: GET_SUM SHALL NOT exist, and the frame is 3 bytes.

Verification
REQ-030 Reset release, no traffic -> all servo_pwm high 1500 us every 20000 us.
REQ-031 Send A5 02 00 (plus 02 with CKSUM) -> frame_ok once; ch2 pulse becomes 1000 us from the next period; other channels unchanged.
REQ-032 Send A5 01 FF (plus FE) -> ch1 pulse = 2000 us (clamped).
REQ-033 Send A5 07 64 with N_CH=4 -> frame_err, no channel changes.
REQ-034 Byte with stop bit forced low mid-frame -> frame_err; next valid frame accepted.
REQ-035 CKSUM build: A5 00 64 00 -> frame_err, ch0 unchanged; assert rst during byte 2 -> outputs 0, then a full valid frame succeeds.

Source files
------------

// File: rtl/uart_servo_multi.sv
// UART-commanded multi-channel hobby-servo PWM generator: 8N1 receiver, frame parser, shared 20 ms frame.
// Define UART_SERVO_CKSUM_EN to require a trailing checksum byte (channel ^ position).
module uart_servo_multi #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int N_CH      = 4,
  parameter int RESET_POS = 125
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_pin,
  output logic [N_CH-1:0] servo_pwm,
  output logic            frame_ok,
  output logic            frame_err
);

  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  localparam int BW     = $clog2(BIT + 1);
  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int DW     = $clog2(DIV + 1);
  localparam int PERIOD = 20000;
  localparam logic [7:0] N_CH_B = 8'(N_CH);
  localparam logic [7:0] RST_POS_B = 8'(RESET_POS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef UART_SERVO_CKSUM_EN
  typedef enum logic [2:0] {P_IDLE, P_GET_CH, P_GET_POS, P_GET_SUM, P_COMMIT} p_state_t;
`else
  typedef enum logic [2:0] {P_IDLE, P_GET_CH, P_GET_POS, P_COMMIT} p_state_t;
`endif

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [BW-1:0]   rx_tmr_q, rx_tmr_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld_q, byte_vld_d, byte_err_q, byte_err_d;

  p_state_t        p_state_q, p_state_d;
  logic [7:0]      ch_q, ch_d, pos_q, pos_d, pos_clamped;
  logic            frame_good;
`ifdef UART_SERVO_CKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic [DW-1:0]   div_q, div_d;
  logic            tick;
  logic [14:0]     cnt_q, cnt_d;
  logic [7:0]      staged_q [N_CH];
  logic [7:0]      staged_d [N_CH];
  logic [7:0]      active_q [N_CH];
  logic [7:0]      active_d [N_CH];
  logic [N_CH-1:0] pwm_q, pwm_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      p_state_q  <= P_IDLE;
      ch_q       <= '0;
      pos_q      <= '0;
`ifdef UART_SERVO_CKSUM_EN
      sum_q      <= '0;
`endif
      div_q      <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        staged_q[i] <= RST_POS_B;
        active_q[i] <= RST_POS_B;
      end
    end else begin
      rx_meta_q  <= rx_pin;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      byte_vld_q <= byte_vld_d;
      byte_err_q <= byte_err_d;
      p_state_q  <= p_state_d;
      ch_q       <= ch_d;
      pos_q      <= pos_d;
`ifdef UART_SERVO_CKSUM_EN
      sum_q      <= sum_d;
`endif
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      staged_q   <= staged_d;
      active_q   <= active_d;
    end
  end

  // Receiver: timer is a down-counter; all sampling happens when it reaches zero.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    byte_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tmr_d   = BW'(HALF - 1);
        end
      end
      RX_START: begin
        if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 1'b1;
        else if (!rx_sync_q) begin
          rx_state_d = RX_DATA;
          rx_tmr_d   = BW'(BIT - 1);
          rx_idx_d   = '0;
        end else rx_state_d = RX_IDLE;
      end
      RX_DATA: begin
        if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 1'b1;
        else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_tmr_d   = BW'(BIT - 1);
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else rx_idx_d = rx_idx_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 1'b1;
        else begin
          rx_state_d = RX_IDLE;
          byte_vld_d = rx_sync_q;
          byte_err_d = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign pos_clamped = (pos_q > 8'd250) ? 8'd250 : pos_q;
`ifdef UART_SERVO_CKSUM_EN
  assign frame_good = (ch_q < N_CH_B) && (sum_q == (ch_q ^ pos_q));
`else
  assign frame_good = (ch_q < N_CH_B);
`endif
  assign frame_ok  = (p_state_q == P_COMMIT) && frame_good;
  assign frame_err = !frame_ok && (((p_state_q == P_COMMIT) && !frame_good) || byte_err_q);

  // Parser: 0xA5 only synchronises in IDLE; inside a frame it is ordinary data.
  always_comb begin
    p_state_d = p_state_q;
    ch_d      = ch_q;
    pos_d     = pos_q;
`ifdef UART_SERVO_CKSUM_EN
    sum_d     = sum_q;
`endif
    if (p_state_q == P_COMMIT) p_state_d = P_IDLE;
    else if (byte_err_q) p_state_d = P_IDLE;
    else if (byte_vld_q) begin
      case (p_state_q)
        P_IDLE:   if (rx_shift_q == 8'hA5) p_state_d = P_GET_CH;
        P_GET_CH: begin
          ch_d      = rx_shift_q;
          p_state_d = P_GET_POS;
        end
        P_GET_POS: begin
          pos_d     = rx_shift_q;
`ifdef UART_SERVO_CKSUM_EN
          p_state_d = P_GET_SUM;
        end
        P_GET_SUM: begin
          sum_d     = rx_shift_q;
`endif
          p_state_d = P_COMMIT;
        end
        default:  p_state_d = P_IDLE;
      endcase
    end
  end

  // Staged values move to active only at the period wrap so pulses are never cut short.
  always_comb begin
    staged_d = staged_q;
    active_d = active_q;
    tick     = (div_q == '0);
    div_d    = tick ? DW'(DIV - 1) : div_q - 1'b1;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (frame_ok && (ch_q == 8'(i))) staged_d[i] = pos_clamped;
    end
    if (tick) begin
      if (cnt_q == 15'(PERIOD - 1)) begin
        cnt_d    = '0;
        active_d = staged_d;
      end else cnt_d = cnt_q + 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = cnt_q < (15'd1000 + {5'b0, active_q[i], 2'b00});
    end
  end

  assign servo_pwm = pwm_q;

endmodule

// File: tb/tb_uart_servo_multi.sv
// Directed bench for uart_servo_multi at 1 MHz / 100 kBd (1 clock per microsecond, 10 clocks per bit).
module tb_uart_servo_multi;
  localparam int BIT = 10;
`ifdef UART_SERVO_CKSUM_EN
  localparam int CK_ERR = 1;
`else
  localparam int CK_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic [3:0] servo_pwm;
  logic       frame_ok, frame_err;

  int n_checks = 0, n_errs = 0, ok_cnt = 0, err_cnt = 0, cyc = 0;
  int meas[4];
  int t_start, t0, ok_snap, err_snap;

  uart_servo_multi #(.CLK_HZ(1_000_000), .BAUD(100_000), .N_CH(4), .RESET_POS(125)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin),
    .servo_pwm(servo_pwm), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok || frame_err) begin
      n_checks++;
      assert (!(frame_ok && frame_err)) else begin
        n_errs++;
        $error("FAIL ok_err_excl: observed ok=%0b err=%0b expected not both", frame_ok, frame_err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] pos);
    send_byte(8'hA5, 1'b1);
    send_byte(ch, 1'b1);
    send_byte(pos, 1'b1);
`ifdef UART_SERVO_CKSUM_EN
    send_byte(ch ^ pos, 1'b1);
`endif
  endtask

  task automatic wait_start();
    logic prev;
    logic found;
    int   n;
    prev  = servo_pwm[0];
    found = 1'b0;
    n     = 0;
    while (!found && n < 25000) begin
      @(negedge clk);
      n++;
      if (servo_pwm[0] && !prev) found = 1'b1;
      prev = servo_pwm[0];
    end
    check("period_start_seen", 32'(found), 32'd1);
    t_start = cyc;
  endtask

  task automatic measure();
    for (int c = 0; c < 4; c++) meas[c] = 0;
    for (int k = 0; k < 2100; k++) begin
      for (int c = 0; c < 4; c++) if (servo_pwm[c]) meas[c]++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_pwm", 32'(servo_pwm), 32'd0);
    check("rst_ok", 32'(frame_ok), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b1;

    // Period 0: defaults, with a ch2 commit landing while the pulses are still high.
    wait_start();
    t0 = t_start;
    fork
      measure();
      begin
        repeat (50) @(negedge clk);
        send_frame(8'h02, 8'h00);
      end
    join
    check("p0_ch0", meas[0], 1500);
    check("p0_ch1", meas[1], 1500);
    check("p0_ch2", meas[2], 1500);
    check("p0_ch3", meas[3], 1500);
    check("ok_after_ch2", ok_cnt, 1);
    check("err_after_ch2", err_cnt, 0);

    send_byte(8'h11, 1'b1);
    check("junk_no_err", err_cnt, 0);
    check("junk_no_ok", ok_cnt, 1);

    send_frame(8'h01, 8'hFF);
    check("ok_clamp", ok_cnt, 2);

    send_frame(8'h07, 8'h64);
    check("err_bad_ch", err_cnt, 1);
    check("ok_bad_ch", ok_cnt, 2);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h32, 1'b0);
    check("err_stop_low", err_cnt, 2);

    send_frame(8'h03, 8'h32);
    send_frame(8'h03, 8'h19);
    check("ok_two_commits", ok_cnt, 4);

`ifdef UART_SERVO_CKSUM_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'h00, 1'b1);
    check("err_cksum", err_cnt, 3);
`endif

    send_frame(8'h00, 8'hA5);
    check("ok_a5_as_pos", ok_cnt, 5);
    check("err_total_p0", err_cnt, 2 + CK_ERR);

    // Period 1: staged values now active.
    wait_start();
    check("period_len", t_start - t0, 20000);
    measure();
    check("p1_ch0", meas[0], 1660);
    check("p1_ch1", meas[1], 2000);
    check("p1_ch2", meas[2], 1000);
    check("p1_ch3", meas[3], 1100);

    // Reset in the middle of the second byte.
    send_byte(8'hA5, 1'b1);
    rx_pin = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pwm", 32'(servo_pwm), 32'd0);
    check("midrst_ok", 32'(frame_ok), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    ok_snap  = ok_cnt;
    err_snap = err_cnt;
    rst = 1'b1;
    wait_start();
    fork
      measure();
      begin
        repeat (50) @(negedge clk);
        send_frame(8'h03, 8'h00);
      end
    join
    check("post_rst_ch0", meas[0], 1500);
    check("post_rst_ch1", meas[1], 1500);
    check("post_rst_ch3", meas[3], 1500);
    check("post_rst_ok", ok_cnt, ok_snap + 1);
    check("post_rst_err", err_cnt, err_snap);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
